// File: rtl/z80_io_initiator.sv
// Wishbone-controlled initiator of Z80 I/O read/write machine cycles (T1, T2, TW, T3).
// Optional macro Z80_WAIT_EN adds the z80_wait_b input, which stretches TW while WAIT is low.
module z80_io_initiator #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0100,
  parameter logic [31:0] CMD_ADDRESS    = BASE_ADDRESS + 32'd0,
  parameter logic [31:0] RESULT_ADDRESS = BASE_ADDRESS + 32'd4,
  parameter logic [31:0] STATUS_ADDRESS = BASE_ADDRESS + 32'd8,
  parameter logic [31:0] TIMING_ADDRESS = BASE_ADDRESS + 32'd12
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        wb_cyc_in,
  input  logic        wb_stb_in,
  input  logic        wb_we_in,
  input  logic [31:0] wb_addr_in,
  input  logic [31:0] wb_data_in,
  output logic        wb_ack_out,
  output logic [31:0] wb_data_out,
  output logic [7:0]  z80_address_bus_out,
  output logic [7:0]  z80_data_bus_out,
  output logic        z80_data_oe,
  input  logic [7:0]  z80_data_bus_in,
  output logic        z80_ioreq_b,
  output logic        z80_read_strobe_b,
  output logic        z80_write_strobe_b,
  output logic        z80_m1,
`ifdef Z80_WAIT_EN
  input  logic        z80_wait_b,
`endif
  output logic        irq_out
);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3} state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [3:0]  tw_left_q;
  logic        dir_q;
  logic [7:0]  addr_q;
  logic [7:0]  dout_q;
  logic [7:0]  result_q;
  logic        oe_q;
  logic        ioreq_b_q;
  logic        rd_b_q;
  logic        wr_b_q;
  logic        irq_q;
  logic        done_q, done_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  tdiv_q;
  logic [3:0]  waits_q;
  logic        req_q;
  logic        ack_q;
  logic [31:0] rdata_q, rdata_d;

  logic wb_req, wb_start;
  logic hit_cmd, hit_result, hit_status, hit_timing, decoded;
  logic cmd_wr, status_wr, timing_wr, result_rd;
  logic busy, accept, cycle_end, wait_hold;
  logic unused_wb_data;

  // Register side effects fire once per access, on the rising edge of cyc&stb.
  assign wb_req     = wb_cyc_in & wb_stb_in;
  assign wb_start   = wb_req & ~req_q;
  assign hit_cmd    = (wb_addr_in == CMD_ADDRESS);
  assign hit_result = (wb_addr_in == RESULT_ADDRESS);
  assign hit_status = (wb_addr_in == STATUS_ADDRESS);
  assign hit_timing = (wb_addr_in == TIMING_ADDRESS);
  assign decoded    = hit_cmd | hit_result | hit_status | hit_timing;
  assign cmd_wr     = wb_start & wb_we_in & hit_cmd;
  assign status_wr  = wb_start & wb_we_in & hit_status;
  assign timing_wr  = wb_start & wb_we_in & hit_timing;
  assign result_rd  = wb_start & ~wb_we_in & hit_result;

  assign busy      = (state_q != S_IDLE);
  assign accept    = cmd_wr & ~busy;
  assign cycle_end = (state_q == S_T3) && (cnt_q == 8'd0);

  assign unused_wb_data = ^wb_data_in[31:17];

`ifdef Z80_WAIT_EN
  logic [1:0] wait_sync_q;

  // Resets to "not waiting" so a cycle can never stall straight out of reset.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) wait_sync_q <= 2'b11;
    else          wait_sync_q <= {wait_sync_q[0], z80_wait_b};
  end

  assign wait_hold = ~wait_sync_q[1];
`else
  assign wait_hold = 1'b0;
`endif

  always_comb begin
    done_d = done_q;
    if ((status_wr && wb_data_in[1]) || result_rd) done_d = 1'b0;
    if (cycle_end) done_d = 1'b1;

    overrun_d = overrun_q;
    if (status_wr && wb_data_in[2]) overrun_d = 1'b0;
    if (cmd_wr && busy) overrun_d = 1'b1;

    rdata_d = 32'd0;
    if (hit_cmd)         rdata_d = {15'd0, dir_q, dout_q, addr_q};
    else if (hit_result) rdata_d = {24'd0, result_q};
    else if (hit_status) rdata_d = {29'd0, overrun_q, done_q, busy};
    else if (hit_timing) rdata_d = {20'd0, waits_q, tdiv_q};
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      req_q     <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= 32'd0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      tdiv_q    <= 8'd3;
      waits_q   <= 4'd0;
    end else begin
      req_q     <= wb_req;
      ack_q     <= wb_start & decoded;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      if (wb_start && !wb_we_in && decoded) rdata_q <= rdata_d;
      if (timing_wr && !busy) begin
        tdiv_q  <= wb_data_in[7:0];
        waits_q <= wb_data_in[11:8];
      end
    end
  end

  // Each non-idle state lasts TDIV+1 clocks; bus outputs change only on state transitions.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      tw_left_q <= 4'd0;
      dir_q     <= 1'b0;
      addr_q    <= 8'd0;
      dout_q    <= 8'd0;
      result_q  <= 8'd0;
      oe_q      <= 1'b0;
      ioreq_b_q <= 1'b1;
      rd_b_q    <= 1'b1;
      wr_b_q    <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (accept) begin
          state_q <= S_T1;
          cnt_q   <= tdiv_q;
          addr_q  <= wb_data_in[7:0];
          dout_q  <= wb_data_in[15:8];
          dir_q   <= wb_data_in[16];
          oe_q    <= wb_data_in[16];
        end
      end else if (cnt_q != 8'd0) begin
        cnt_q <= cnt_q - 8'd1;
      end else begin
        cnt_q <= tdiv_q;
        case (state_q)
          S_T1: begin
            state_q   <= S_T2;
            ioreq_b_q <= 1'b0;
            rd_b_q    <= dir_q;
            wr_b_q    <= ~dir_q;
          end
          S_T2: begin
            state_q   <= S_TW;
            tw_left_q <= waits_q;
          end
          S_TW: begin
            // A held WAIT repeats the TW state without consuming one of the programmed waits.
            if (!wait_hold) begin
              if (tw_left_q != 4'd0) tw_left_q <= tw_left_q - 4'd1;
              else                   state_q   <= S_T3;
            end
          end
          S_T3: begin
            state_q   <= S_IDLE;
            ioreq_b_q <= 1'b1;
            rd_b_q    <= 1'b1;
            wr_b_q    <= 1'b1;
            oe_q      <= 1'b0;
            irq_q     <= 1'b1;
            if (!dir_q) result_q <= z80_data_bus_in;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign wb_ack_out          = ack_q;
  assign wb_data_out         = rdata_q;
  assign z80_address_bus_out = addr_q;
  assign z80_data_bus_out    = dout_q;
  assign z80_data_oe         = oe_q;
  assign z80_ioreq_b         = ioreq_b_q;
  assign z80_read_strobe_b   = rd_b_q;
  assign z80_write_strobe_b  = wr_b_q;
  assign z80_m1              = 1'b1;
  assign irq_out             = irq_q;

endmodule

// File: tb/tb_z80_io_initiator.sv
// Bench for z80_io_initiator: a cycle-level model of the Z80 I/O bus timing and register file,
// checked against the DUT on every clock, plus hand-computed literal expectations.
module tb_z80_io_initiator;

  localparam logic [31:0] BASE = 32'h3000_0100;
  localparam logic [31:0] CMD  = BASE;
  localparam logic [31:0] RES  = BASE + 32'd4;
  localparam logic [31:0] STAT = BASE + 32'd8;
  localparam logic [31:0] TIM  = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        wb_cyc_in = 1'b0, wb_stb_in = 1'b0, wb_we_in = 1'b0;
  logic [31:0] wb_addr_in = 32'd0, wb_data_in = 32'd0;
  logic        wb_ack_out;
  logic [31:0] wb_data_out;
  logic [7:0]  z80_address_bus_out, z80_data_bus_out;
  logic        z80_data_oe;
  logic [7:0]  busIn = 8'd0;
  logic        z80_ioreq_b, z80_read_strobe_b, z80_write_strobe_b, z80_m1, irq_out;
`ifdef Z80_WAIT_EN
  logic        waitB = 1'b1;
`endif

  z80_io_initiator dut (
    .clk(clk), .reset_b(reset_b),
    .wb_cyc_in(wb_cyc_in), .wb_stb_in(wb_stb_in), .wb_we_in(wb_we_in),
    .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
    .wb_ack_out(wb_ack_out), .wb_data_out(wb_data_out),
    .z80_address_bus_out(z80_address_bus_out), .z80_data_bus_out(z80_data_bus_out),
    .z80_data_oe(z80_data_oe), .z80_data_bus_in(busIn),
    .z80_ioreq_b(z80_ioreq_b), .z80_read_strobe_b(z80_read_strobe_b),
    .z80_write_strobe_b(z80_write_strobe_b), .z80_m1(z80_m1),
`ifdef Z80_WAIT_EN
    .z80_wait_b(waitB),
`endif
    .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  int nTests = 0, nFails = 0;
  int edgeCnt = 0;
  int cntWrLow = 0, cntRdLow = 0, cntIoreqLow = 0, cntOe = 0, cntIrq = 0;

  // Model: a bus cycle accepted at edge mStart occupies mLen clocks; phase = k/(TDIV+1).
  bit          modelOn = 1'b1;
  bit          mActive = 1'b0;
  int          mStart = 0, mLen = 0;
  bit          mDir = 1'b0;
  logic [7:0]  mAddr = 8'd0, mData = 8'd0, mResult = 8'd0;
  int          mTdiv = 3, mWaits = 0;
  bit          mDone = 1'b0, mOverrun = 1'b0;

  bit          pendValid = 1'b0, pendWe = 1'b0, pendDecoded = 1'b0;
  logic [31:0] pendAddr = 32'd0, pendData = 32'd0, pendExp = 32'd0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mActive = 1'b0; mDir = 1'b0; mAddr = 8'd0; mData = 8'd0; mResult = 8'd0;
    mTdiv = 3; mWaits = 0; mDone = 1'b0; mOverrun = 1'b0; pendValid = 1'b0;
  endtask

  // Effects of a Wishbone access that the DUT sees at the edge just taken.
  task automatic applyEdgeEffects();
    if (pendValid) begin
      pendValid   = 1'b0;
      pendDecoded = (pendAddr == CMD) || (pendAddr == RES) || (pendAddr == STAT) || (pendAddr == TIM);
      pendExp     = 32'd0;
      if (pendAddr == RES)  pendExp = {24'd0, mResult};
      if (pendAddr == STAT) pendExp = {29'd0, mOverrun, mDone, mActive};
      if (pendAddr == TIM)  pendExp = {20'd0, 4'(mWaits), 8'(mTdiv)};
      if (modelOn) begin
        if (pendWe && pendAddr == CMD) begin
          if (!mActive) begin
            mActive = 1'b1;
            mStart  = edgeCnt;
            mAddr   = pendData[7:0];
            mData   = pendData[15:8];
            mDir    = pendData[16];
            mLen    = (4 + mWaits) * (mTdiv + 1);
          end else begin
            mOverrun = 1'b1;
          end
        end
        if (pendWe && pendAddr == STAT) begin
          if (pendData[1]) mDone = 1'b0;
          if (pendData[2]) mOverrun = 1'b0;
        end
        if (pendWe && pendAddr == TIM && !mActive) begin
          mTdiv  = int'(pendData[7:0]);
          mWaits = int'(pendData[11:8]);
        end
        if (!pendWe && pendAddr == RES) mDone = 1'b0;
      end
    end
  endtask

  task automatic compareCycle();
    int k;
    logic expIoreq, expRd, expWr, expOe, expIrq;
    if (!z80_write_strobe_b) cntWrLow++;
    if (!z80_read_strobe_b)  cntRdLow++;
    if (!z80_ioreq_b)        cntIoreqLow++;
    if (z80_data_oe)         cntOe++;
    if (irq_out)             cntIrq++;
    if (modelOn) begin
      k = edgeCnt - mStart;
      expIoreq = 1'b1; expRd = 1'b1; expWr = 1'b1; expOe = 1'b0; expIrq = 1'b0;
      if (mActive) begin
        if (k < mLen) begin
          expOe = mDir;
          if (k >= mTdiv + 1) begin
            expIoreq = 1'b0;
            expRd    = mDir;
            expWr    = !mDir;
          end
        end else begin
          expIrq  = (k == mLen);
          mActive = 1'b0;
          mDone   = 1'b1;
          if (!mDir) mResult = busIn;
        end
      end
      checkOutput("ioreq_b", z80_ioreq_b, expIoreq);
      checkOutput("read_strobe_b", z80_read_strobe_b, expRd);
      checkOutput("write_strobe_b", z80_write_strobe_b, expWr);
      checkOutput("data_oe", z80_data_oe, expOe);
      checkOutput("irq", irq_out, expIrq);
      checkOutput("m1", z80_m1, 1'b1);
      checkOutput("address", z80_address_bus_out, mAddr);
      if (expOe) checkOutput("data_out", z80_data_bus_out, mData);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    edgeCnt++;
    #1;
    applyEdgeEffects();
    @(negedge clk);
    compareCycle();
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  // One Wishbone access starting at a falling edge; returns at a falling edge two clocks later.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data,
                               output logic [31:0] rd);
    wb_cyc_in = 1'b1; wb_stb_in = 1'b1; wb_we_in = we;
    wb_addr_in = addr; wb_data_in = data;
    pendValid = 1'b1; pendWe = we; pendAddr = addr; pendData = data;
    stepCycle();
    checkOutput("wb_ack", wb_ack_out, pendDecoded);
    rd = wb_data_out;
    if (modelOn && pendDecoded && !we && addr != CMD) checkOutput("wb_rdata", wb_data_out, pendExp);
    wb_cyc_in = 1'b0; wb_stb_in = 1'b0; wb_we_in = 1'b0;
    stepCycle();
    checkOutput("wb_ack_release", wb_ack_out, 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    int s0, s1, s2, s3, s4;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_ioreq_b", z80_ioreq_b, 1'b1);
    checkOutput("rst_rd_b", z80_read_strobe_b, 1'b1);
    checkOutput("rst_wr_b", z80_write_strobe_b, 1'b1);
    checkOutput("rst_m1", z80_m1, 1'b1);
    checkOutput("rst_oe", z80_data_oe, 1'b0);
    checkOutput("rst_addr", z80_address_bus_out, 8'h00);
    checkOutput("rst_dout", z80_data_bus_out, 8'h00);
    checkOutput("rst_ack", wb_ack_out, 1'b0);
    checkOutput("rst_rdata", wb_data_out, 32'h0);
    checkOutput("rst_irq", irq_out, 1'b0);
    reset_b = 1'b1;
    stepCycle();
    applyStimulus(1'b0, STAT, 32'h0, rd); checkOutput("status_reset", rd, 32'h0);
    applyStimulus(1'b0, TIM, 32'h0, rd);  checkOutput("timing_reset", rd, 32'h003);

    // Write 0x5A to port 0x80 with default timing
    s0 = cntWrLow; s1 = cntIoreqLow; s2 = cntOe; s3 = cntIrq;
    applyStimulus(1'b1, CMD, 32'h0001_5A80, rd);
    waitCycles(18);
    checkOutput("wr_strobe_clks", cntWrLow - s0, 12);
    checkOutput("wr_ioreq_clks", cntIoreqLow - s1, 12);
    checkOutput("wr_total_clks", cntOe - s2, 16);
    checkOutput("wr_irq_pulses", cntIrq - s3, 1);
    checkOutput("wr_addr_held", z80_address_bus_out, 8'h80);
    applyStimulus(1'b0, STAT, 32'h0, rd); checkOutput("status_done", rd, 32'h2);

    // Read port 0x82 returning 0xC3
    busIn = 8'hC3;
    s0 = cntRdLow; s2 = cntOe;
    applyStimulus(1'b1, CMD, 32'h0000_0082, rd);
    waitCycles(18);
    checkOutput("rd_strobe_clks", cntRdLow - s0, 12);
    checkOutput("rd_oe_clks", cntOe - s2, 0);
    applyStimulus(1'b0, RES, 32'h0, rd);  checkOutput("result_c3", rd, 32'hC3);
    applyStimulus(1'b0, STAT, 32'h0, rd); checkOutput("done_cleared_by_read", rd, 32'h0);

    // Overrun: second command two clocks after the first is dropped
    applyStimulus(1'b1, CMD, 32'h0001_1181, rd);
    applyStimulus(1'b1, CMD, 32'h0001_2284, rd);
    waitCycles(16);
    checkOutput("overrun_addr_kept", z80_address_bus_out, 8'h81);
    applyStimulus(1'b0, STAT, 32'h0, rd); checkOutput("status_overrun", rd, 32'h6);
    applyStimulus(1'b1, STAT, 32'h4, rd);
    applyStimulus(1'b0, STAT, 32'h0, rd); checkOutput("overrun_cleared", rd, 32'h2);
    applyStimulus(1'b1, STAT, 32'h2, rd);
    applyStimulus(1'b0, STAT, 32'h0, rd); checkOutput("done_cleared_by_w1c", rd, 32'h0);

    // TIMING writes while busy are ignored
    applyStimulus(1'b1, CMD, 32'h0001_3388, rd);
    applyStimulus(1'b1, TIM, 32'h0000_0200, rd);
    waitCycles(16);
    applyStimulus(1'b0, TIM, 32'h0, rd); checkOutput("timing_busy_ignored", rd, 32'h003);
    applyStimulus(1'b1, TIM, 32'h0000_0200, rd);
    applyStimulus(1'b0, TIM, 32'h0, rd); checkOutput("timing_written", rd, 32'h200);

    // TDIV=0, WAITS=2: six clocks, three TW
    s0 = cntWrLow; s2 = cntOe; s3 = cntIrq;
    applyStimulus(1'b1, CMD, 32'h0001_A55A, rd);
    waitCycles(6);
    checkOutput("fast_total_clks", cntOe - s2, 6);
    checkOutput("fast_strobe_clks", cntWrLow - s0, 5);
    checkOutput("fast_irq_pulses", cntIrq - s3, 1);

    // CMD in the final T3 clock is an overrun
    busIn = 8'h5E;
    applyStimulus(1'b1, CMD, 32'h0000_0011, rd);
    waitCycles(4);
    applyStimulus(1'b1, CMD, 32'h0001_0022, rd);
    applyStimulus(1'b0, STAT, 32'h0, rd); checkOutput("final_t3_overrun", rd, 32'h6);
    checkOutput("final_t3_addr", z80_address_bus_out, 8'h11);
    applyStimulus(1'b0, RES, 32'h0, rd);  checkOutput("result_5e", rd, 32'h5E);
    applyStimulus(1'b1, STAT, 32'h6, rd);

    // CMD in the clock after returning to IDLE is accepted
    applyStimulus(1'b1, CMD, 32'h0000_0033, rd);
    waitCycles(5);
    applyStimulus(1'b1, CMD, 32'h0001_0044, rd);
    waitCycles(8);
    checkOutput("idle_next_accept_addr", z80_address_bus_out, 8'h44);
    applyStimulus(1'b0, STAT, 32'h0, rd); checkOutput("idle_next_no_overrun", rd, 32'h2);

    // done clear in the completion clock: set wins
    applyStimulus(1'b1, STAT, 32'h2, rd);
    applyStimulus(1'b1, CMD, 32'h0000_0055, rd);
    waitCycles(4);
    applyStimulus(1'b1, STAT, 32'h2, rd);
    applyStimulus(1'b0, STAT, 32'h0, rd); checkOutput("done_set_wins", rd, 32'h2);

    // WAITS=15, TDIV=0: 16 TW states, 19 clocks total
    applyStimulus(1'b1, TIM, 32'h0000_0F00, rd);
    s1 = cntIoreqLow; s2 = cntOe;
    applyStimulus(1'b1, CMD, 32'h0001_0166, rd);
    waitCycles(20);
    checkOutput("max_waits_total_clks", cntOe - s2, 19);
    checkOutput("max_waits_ioreq_clks", cntIoreqLow - s1, 18);

    // Undecoded address is never acknowledged
    applyStimulus(1'b1, BASE + 32'd16, 32'hFFFF_FFFF, rd);
    applyStimulus(1'b0, BASE + 32'd16, 32'h0, rd);
    applyStimulus(1'b0, STAT, 32'h0, rd); checkOutput("undecoded_no_effect", rd, 32'h2);

    // Asynchronous reset during T2
    applyStimulus(1'b1, TIM, 32'h0000_0003, rd);
    applyStimulus(1'b1, CMD, 32'h0001_7799, rd);
    waitCycles(4);
    checkOutput("pre_reset_in_t2", z80_write_strobe_b, 1'b0);
    #2 reset_b = 1'b0;
    #1;
    checkOutput("async_rst_wr_b", z80_write_strobe_b, 1'b1);
    checkOutput("async_rst_ioreq_b", z80_ioreq_b, 1'b1);
    checkOutput("async_rst_oe", z80_data_oe, 1'b0);
    checkOutput("async_rst_addr", z80_address_bus_out, 8'h00);
    modelReset();
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    stepCycle();
    applyStimulus(1'b0, STAT, 32'h0, rd); checkOutput("post_reset_status", rd, 32'h0);
    applyStimulus(1'b0, TIM, 32'h0, rd);  checkOutput("post_reset_timing", rd, 32'h003);

`ifdef Z80_WAIT_EN
    // WAIT held low through TW stretches the read until the synchronised release
    modelOn = 1'b0;
    busIn = 8'h77;
    s3 = cntIrq;
    applyStimulus(1'b1, CMD, 32'h0000_0044, rd);
    waitB = 1'b0;
    waitCycles(20);
    checkOutput("wait_no_irq_while_held", cntIrq - s3, 0);
    checkOutput("wait_still_in_cycle", z80_ioreq_b, 1'b0);
    waitB = 1'b1;
    s4 = 0;
    while ((cntIrq - s3) == 0 && s4 < 40) begin
      stepCycle();
      s4++;
    end
    checkOutput("wait_irq_arrived", cntIrq - s3, 1);
    checkOutput("wait_release_latency_ok", (s4 >= 4 && s4 <= 12) ? 32'd1 : 32'd0, 32'd1);
    applyStimulus(1'b0, RES, 32'h0, rd); checkOutput("wait_result", rd, 32'h77);
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule
